// File: rtl/pass_lock_ctrl.sv
// Keypad lock session controller: password check, failure counting, timed lockout, digit routing.
// Optional idle auto-close in OPEN is built when PLC_TIMEOUT_EN is defined.
module pass_lock_ctrl #(
    parameter int                    PASS_LEN       = 4,
    parameter logic [4*PASS_LEN-1:0] PASSWORD       = 16'h3A5C,
    parameter int                    MAX_FAIL       = 3,
    parameter int                    LOCK_CYCLES    = 16,
    parameter int                    DATA_LEN       = 4,
    parameter int                    TIMEOUT_CYCLES = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            confirm,
    input  logic                            logout,
    input  logic [3:0]                      pass_data,
    output logic                            en_left,
    output logic                            en_right,
    output logic [3:0]                      dout,
    output logic                            unlocked,
    output logic                            locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
    output logic [2:0]                      state
);

    localparam int IDX_W  = (PASS_LEN > 1) ? $clog2(PASS_LEN) : 1;
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);
    localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam int DATA_W = $clog2(DATA_LEN + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_FAIL  = 3'd2,
        ST_LOCK  = 3'd3,
        ST_OPEN  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    generate
        if (MAX_FAIL < 1 || TIMEOUT_CYCLES < 1 || PASS_LEN < 1 ||
            LOCK_CYCLES < 1 || DATA_LEN < 1) begin : g_bad_params
            $error("pass_lock_ctrl: invalid parameter set");
        end
    endgenerate

    function automatic logic [3:0] digit_at(input logic [IDX_W-1:0] i);
        return PASSWORD[4*i +: 4];
    endfunction

    state_t              state_r, state_s;
    logic                confirm_q_r;
    logic                cpulse_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic                mismatch_r, mismatch_s;
    logic [FAIL_W-1:0]   fail_r, fail_s;
    logic [LOCK_W-1:0]   lock_r, lock_s;
    logic [DATA_W-1:0]   data_r, data_s;
    logic                en_left_r, en_left_s;
    logic                en_right_r, en_right_s;
    logic [3:0]          dout_r, dout_s;
    logic                unlocked_r, locked_r;
`ifdef PLC_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0]   idle_r, idle_s;
`endif

    assign cpulse_s = confirm & ~confirm_q_r;

    // Next-state, counter and strobe decode.
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        mismatch_s = mismatch_r;
        fail_s     = fail_r;
        lock_s     = lock_r;
        data_s     = data_r;
        en_left_s  = 1'b0;
        en_right_s = 1'b0;
        dout_s     = dout_r;
`ifdef PLC_TIMEOUT_EN
        idle_s     = {IDLE_W{1'b0}};
`endif
        case (state_r)
            ST_IDLE: begin
                state_s = ST_CHECK;
            end
            ST_CHECK: begin
                if (cpulse_s) begin
                    // Evaluate only after the full digit count so timing leaks nothing.
                    if (idx_r == IDX_W'(PASS_LEN - 1)) begin
                        idx_s      = {IDX_W{1'b0}};
                        mismatch_s = 1'b0;
                        if (mismatch_r || (pass_data != digit_at(idx_r))) begin
                            state_s = ST_FAIL;
                        end else begin
                            state_s = ST_OPEN;
                            fail_s  = {FAIL_W{1'b0}};
                        end
                    end else begin
                        idx_s      = idx_r + 1'b1;
                        mismatch_s = mismatch_r | (pass_data != digit_at(idx_r));
                    end
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_FAIL: begin
                if (fail_r != FAIL_W'(MAX_FAIL)) begin
                    fail_s = fail_r + 1'b1;
                end else begin
                    fail_s = fail_r;
                end
                if (fail_s == FAIL_W'(MAX_FAIL)) begin
                    state_s = ST_LOCK;
                    lock_s  = {LOCK_W{1'b0}};
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_LOCK: begin
                if (lock_r == LOCK_W'(LOCK_CYCLES - 1)) begin
                    state_s = ST_CHECK;
                    fail_s  = {FAIL_W{1'b0}};
                    lock_s  = {LOCK_W{1'b0}};
                end else begin
                    lock_s  = lock_r + 1'b1;
                end
            end
            ST_OPEN: begin
                if (cpulse_s) begin
                    dout_s     = pass_data;
                    en_left_s  = pass_data[0];
                    en_right_s = ~pass_data[0];
                    data_s     = data_r + 1'b1;
                    if ((data_r == DATA_W'(DATA_LEN - 1)) || logout) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_OPEN;
                    end
                end else if (logout) begin
                    state_s = ST_DONE;
                end else begin
`ifdef PLC_TIMEOUT_EN
                    if (idle_r == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                        state_s = ST_DONE;
                    end else begin
                        idle_s  = idle_r + 1'b1;
                    end
`else
                    state_s = ST_OPEN;
`endif
                end
            end
            ST_DONE: begin
                data_s  = {DATA_W{1'b0}};
                state_s = ST_CHECK;
            end
            default: begin
                state_s    = ST_IDLE;
                idx_s      = {IDX_W{1'b0}};
                mismatch_s = 1'b0;
            end
        endcase
    end

    // Control state, counters and confirm edge history.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            confirm_q_r <= 1'b0;
            idx_r       <= {IDX_W{1'b0}};
            mismatch_r  <= 1'b0;
            fail_r      <= {FAIL_W{1'b0}};
            lock_r      <= {LOCK_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
        end else begin
            state_r     <= state_s;
            confirm_q_r <= confirm;
            idx_r       <= idx_s;
            mismatch_r  <= mismatch_s;
            fail_r      <= fail_s;
            lock_r      <= lock_s;
            data_r      <= data_s;
        end
    end

`ifdef PLC_TIMEOUT_EN
    // Idle counter for OPEN auto-close; held at zero outside OPEN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_r <= {IDLE_W{1'b0}};
        end else begin
            idle_r <= idle_s;
        end
    end
`endif

    // Registered outputs, decoded from the next state so they align with state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en_left_r  <= 1'b0;
            en_right_r <= 1'b0;
            dout_r     <= 4'h0;
            unlocked_r <= 1'b0;
            locked_r   <= 1'b0;
        end else begin
            en_left_r  <= en_left_s;
            en_right_r <= en_right_s;
            dout_r     <= dout_s;
            unlocked_r <= (state_s == ST_OPEN);
            locked_r   <= (state_s == ST_LOCK);
        end
    end

    assign en_left  = en_left_r;
    assign en_right = en_right_r;
    assign dout     = dout_r;
    assign unlocked = unlocked_r;
    assign locked   = locked_r;
    assign fail_cnt = fail_r;
    assign state    = state_r;

endmodule

// File: tb/tb_pass_lock_ctrl.sv
// Directed self-checking bench for pass_lock_ctrl (password 3A5C, 3 failures, 16-cycle lock).
module tb_pass_lock_ctrl;

    logic       clk;
    logic       rst;
    logic       confirm;
    logic       logout;
    logic [3:0] pass_data;
    logic       en_left;
    logic       en_right;
    logic [3:0] dout;
    logic       unlocked;
    logic       locked;
    logic [1:0] fail_cnt;
    logic [2:0] state;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    pass_lock_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .confirm  (confirm),
        .logout   (logout),
        .pass_data(pass_data),
        .en_left  (en_left),
        .en_right (en_right),
        .dout     (dout),
        .unlocked (unlocked),
        .locked   (locked),
        .fail_cnt (fail_cnt),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise confirm for one edge; returns just after the consuming edge with confirm low.
    task automatic pulse(input logic [3:0] d);
        pass_data = d;
        confirm   = 1'b1;
        tick();
        confirm   = 1'b0;
    endtask

    task automatic enter(input logic [3:0] d);
        pulse(d);
        tick();
    endtask

    initial begin
        rst       = 1'b0;
        confirm   = 1'b0;
        logout    = 1'b0;
        pass_data = 4'h0;

        // 1: reset
        repeat (3) tick();
        chk("rst_state",    32'(state),    32'd0);
        chk("rst_unlocked", 32'(unlocked), 32'd0);
        chk("rst_locked",   32'(locked),   32'd0);
        chk("rst_strobes",  32'({en_left, en_right}), 32'd0);
        chk("rst_dout",     32'(dout),     32'd0);
        chk("rst_fail",     32'(fail_cnt), 32'd0);
        rst = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 32'd1);

        // 2: correct password C,5,A,3
        enter(4'hC); enter(4'h5); enter(4'hA);
        chk("pw_mid_state", 32'(state), 32'd1);
        pulse(4'h3);
        chk("open_state",    32'(state),    32'd4);
        chk("open_unlocked", 32'(unlocked), 32'd1);
        chk("open_fail",     32'(fail_cnt), 32'd0);
        tick();

        // 3: digit routing
        pulse(4'h6);
        chk("d6_right", 32'(en_right), 32'd1);
        chk("d6_left",  32'(en_left),  32'd0);
        chk("d6_dout",  32'(dout),     32'h6);
        tick();
        chk("d6_right_off", 32'(en_right), 32'd0);
        chk("d6_dout_hold", 32'(dout),     32'h6);
        pulse(4'h9);
        chk("d9_left",  32'(en_left),  32'd1);
        chk("d9_right", 32'(en_right), 32'd0);
        chk("d9_dout",  32'(dout),     32'h9);
        tick();
        chk("d9_left_off", 32'(en_left), 32'd0);
        chk("d9_state",    32'(state),   32'd4);
        logout = 1'b1;
        tick();
        logout = 1'b0;
        chk("logout_done",     32'(state),    32'd5);
        chk("logout_unlocked", 32'(unlocked), 32'd0);
        tick();
        chk("logout_check", 32'(state), 32'd1);

        // 4: three failed attempts -> lockout
        enter(4'hC); enter(4'h5); enter(4'hA); pulse(4'h4);
        chk("f1_state", 32'(state), 32'd2);
        tick();
        chk("f1_cnt",   32'(fail_cnt), 32'd1);
        chk("f1_check", 32'(state),    32'd1);
        enter(4'hC); enter(4'h5); enter(4'hA); pulse(4'h4);
        tick();
        chk("f2_cnt",   32'(fail_cnt), 32'd2);
        chk("f2_check", 32'(state),    32'd1);
        enter(4'hC); enter(4'h5); enter(4'hA); pulse(4'h4);
        tick();
        chk("f3_state",  32'(state),    32'd3);
        chk("f3_locked", 32'(locked),   32'd1);
        chk("f3_cnt",    32'(fail_cnt), 32'd3);
        for (int i = 1; i < 16; i++) begin
            confirm   = (i % 2 == 1);
            pass_data = 4'hC;
            tick();
            chk("lock_hold",    32'(locked), 32'd1);
            chk("lock_nostrobe", 32'({en_left, en_right}), 32'd0);
        end
        confirm = 1'b0;
        tick();
        chk("unlock_state",  32'(state),    32'd1);
        chk("unlock_locked", 32'(locked),   32'd0);
        chk("unlock_fail",   32'(fail_cnt), 32'd0);

        // 5: held confirm consumes one digit; logout+confirm together
        pass_data = 4'hC;
        confirm   = 1'b1;
        repeat (10) tick();
        confirm = 1'b0;
        chk("hold_state", 32'(state), 32'd1);
        tick();
        enter(4'h5); enter(4'hA); pulse(4'h3);
        chk("hold_open", 32'(state), 32'd4);
        tick();
        logout = 1'b1;
        pulse(4'h2);
        logout = 1'b0;
        chk("lc_right", 32'(en_right), 32'd1);
        chk("lc_left",  32'(en_left),  32'd0);
        chk("lc_dout",  32'(dout),     32'h2);
        chk("lc_done",  32'(state),    32'd5);
        tick();
        chk("lc_check",     32'(state),    32'd1);
        chk("lc_right_off", 32'(en_right), 32'd0);

        // DATA_LEN-th digit closes the session
        enter(4'hC); enter(4'h5); enter(4'hA); enter(4'h3);
        enter(4'h1); enter(4'h2); enter(4'h3);
        chk("dl_still_open", 32'(state), 32'd4);
        pulse(4'h7);
        chk("dl_left", 32'(en_left), 32'd1);
        chk("dl_done", 32'(state),   32'd5);
        tick();
        chk("dl_check", 32'(state), 32'd1);

        // 6: async reset mid-strobe
        enter(4'hC); enter(4'h5); enter(4'hA); enter(4'h3);
        pulse(4'h5);
        chk("pre_rst_left", 32'(en_left), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_state",    32'(state),    32'd0);
        chk("arst_left",     32'(en_left),  32'd0);
        chk("arst_unlocked", 32'(unlocked), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rearm_state", 32'(state), 32'd1);

`ifdef PLC_TIMEOUT_EN
        enter(4'hC); enter(4'h5); enter(4'hA); pulse(4'h3);
        repeat (31) tick();
        chk("to_open", 32'(state), 32'd4);
        tick();
        chk("to_done", 32'(state), 32'd5);
        tick();
        chk("to_check", 32'(state), 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
